lopd_normalizer: RTL
====================

// Module: lopd_normalizer
// PURPOSE
//  Consumer side of the leading-one position detector (LOPD). Takes an
//  un-normalized FP mantissa plus its biased exponent and finds the leading-one
//  position. Left-shifts the mantissa so bit [SIZE_DATA-1] is 1 and subtracts
//  the shift from the exponent. Clamps to denormal on exponent underflow.
//  Sits after the add/sub mantissa stage, before rounding, with valid/ready on
//  both sides.
// PARAMETERS
//  SIZE_DATA  24  mantissa width incl. hidden bit
//  SIZE_EXP    8  biased exponent width
//  SIZE_POS    5  leading-one position width, >= clog2(SIZE_DATA)
// PORTS
//  i_clk        in   1          clock, all state on rising edge
//  i_rst_n      in   1          asynchronous reset, active low
//  i_valid      in   1          input beat valid
//  o_ready      out  1          block can accept input this cycle
//  i_mant       in   SIZE_DATA  un-normalized mantissa
//  i_exp        in   SIZE_EXP   biased exponent of i_mant
//  o_valid      out  1          result valid
//  i_ready      in   1          downstream accepts result
//  o_mant       out  SIZE_DATA  normalized (or denormal-clamped) mantissa
//  o_exp        out  SIZE_EXP   adjusted exponent
//  o_zero_flag  out  1          i_mant was all zeros
//  o_underflow  out  1          exponent clamped to 0 (denormal result)
// BEHAVIOUR
//  - Reset: all outputs 0 and o_ready=1 after release; stage valids cleared.
//  - Position: pos = distance of leading 1 from MSB (MSB set -> 0). zero = (mant==0).
//  - Two-stage pipeline. S1 registers {mant, exp, pos, zero} from the LOPD on
//    the input. S2 registers the shifted result. Latency is 2 cycles from
//    accept (i_valid&&o_ready) to o_valid. Throughput is 1 beat/cycle.
//  - Handshake: transfer in on i_valid&&o_ready; transfer out on o_valid&&i_ready.
//    - S2 loads when it is empty or is being drained in the same cycle.
//    - S1 advances when S2 loads.
//    - o_ready = !s1_valid || s1_advance. This is combinational from i_ready,
//      with no combinational path from i_valid.
//  - While o_valid=1 and i_ready=0, all o_* hold stable. No beat is lost or
//    duplicated. Simultaneous accept and drain on a full pipe is allowed.
//  - Arithmetic rules, using exponent e and position p:
//    - zero: o_mant=0, o_exp=0, o_zero_flag=1, o_underflow=0
//    - e > p: shift=p, o_exp=e-p, o_underflow=0
//    - e <= p, e != 0: shift=e-1, o_exp=0, o_underflow=1
//    - e == 0: shift=0, o_exp=0, o_underflow=1
//  - All subtracts are unsigned in SIZE_EXP bits and never wrap, given the
//    rules above. Shift is a logical left shift with zero fill.
//  - Reset asserted mid-operation: pipeline flushed asynchronously. In-flight
//    beats are discarded and o_valid drops immediately.
// CONFIGURATION
//  LOPD_NORM_ONE_STAGE_EN defined:
//  - S1 register removed; LOPD and shifter are one combinational stage.
//  - Latency 1 cycle; o_ready = !o_valid || i_ready.
//  - Arithmetic and handshake rules unchanged.
//  LOPD_NORM_ONE_STAGE_EN undefined (default): two-stage pipeline as above.
// TESTING (SIZE_DATA=24, SIZE_EXP=8, i_ready=1 unless stated)
//  1. mant=24'h800000, exp=127
//     -> o_mant=24'h800000, o_exp=127, zero=0, uf=0; o_valid 2 cycles after accept.
//  2. mant=24'h000100 (pos=15), exp=100
//     -> o_mant=24'h800000, o_exp=85, uf=0.
//  3. mant=24'h000100, exp=10
//     -> shift 9, o_mant=24'h020000, o_exp=0, uf=1.
//     Also exp=0 -> o_mant=24'h000100, o_exp=0, uf=1.
//  4. mant=0, exp=55
//     -> o_mant=0, o_exp=0, o_zero_flag=1, uf=0.
//  5. Hold i_ready=0 for 5 cycles while presenting beats A, B, C
//     -> A and B accepted, then o_ready=0; o_* hold A stable.
//     Raise i_ready -> A, B, C emerge in order, one per cycle, none lost.
//  6. Stream 4 back-to-back beats, assert i_rst_n=0 after the 2nd accept
//     -> o_valid=0 and o_* = 0 asynchronously.
//     After release, o_ready=1 and no stale beat appears.
//  Repeat 1-6 with LOPD_NORM_ONE_STAGE_EN defined, expecting latency 1.

Source files
------------

// File: rtl/lopd_normalizer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lopd_normalizer_if                                           |
// | Description : Valid/ready bus for the LOPD normalizer. The input beat and  |
// |               the result beat share one bundle.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface lopd_normalizer_if #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_EXP  = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [SIZE_DATA-1:0] i_mant;
  logic [SIZE_EXP-1:0]  i_exp;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_mant;
  logic [SIZE_EXP-1:0]  o_exp;
  logic                 o_zero_flag;
  logic                 o_underflow;

  // The normalizer side: consumes input beats, produces result beats.
  modport slave (
    input  i_valid, i_mant, i_exp, i_ready,
    output o_ready, o_valid, o_mant, o_exp, o_zero_flag, o_underflow
  );

  // The environment side: drives input beats, consumes result beats.
  modport master (
    output i_valid, i_mant, i_exp, i_ready,
    input  o_ready, o_valid, o_mant, o_exp, o_zero_flag, o_underflow
  );
endinterface
`default_nettype wire

// File: rtl/lopd_normalizer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lopd_normalizer                                              |
// | Description : Leading-one detect and left-normalize an FP mantissa, adjust |
// |               the exponent, clamp to denormal on exponent underflow.       |
// |               Define LOPD_NORM_ONE_STAGE_EN for a single-register variant. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lopd_normalizer #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_POS  = 5
) (
  input wire i_clk,
  input wire i_rst_n,
  lopd_normalizer_if.slave bus
);

  localparam int CMP_W = ((SIZE_EXP > SIZE_POS) ? SIZE_EXP : SIZE_POS) + 1;

  // Leading-one detector on the raw input
  logic [SIZE_POS-1:0] w_lopd_pos;
  logic                w_lopd_zero;

  always_comb begin
    w_lopd_pos = '0;
    for (int i = 0; i < SIZE_DATA; i++) begin
      if (bus.i_mant[i]) begin
        w_lopd_pos = SIZE_POS'(SIZE_DATA - 1 - i);
      end
    end
  end

  assign w_lopd_zero = (bus.i_mant == '0);

  // Shifter source: either the S1 register or the LOPD directly
  logic                 w_src_valid;
  logic [SIZE_DATA-1:0] w_sh_mant;
  logic [SIZE_EXP-1:0]  w_sh_exp;
  logic [SIZE_POS-1:0]  w_sh_pos;
  logic                 w_sh_zero;
  logic                 w_in_ready;

  // Output register handshake
  logic                 out_valid_q;
  logic                 w_out_room;
  logic                 w_out_take;

  assign w_out_room = !out_valid_q || bus.i_ready;
  assign w_out_take = w_src_valid && w_out_room;

`ifdef LOPD_NORM_ONE_STAGE_EN

  assign w_src_valid = bus.i_valid;
  assign w_sh_mant   = bus.i_mant;
  assign w_sh_exp    = bus.i_exp;
  assign w_sh_pos    = w_lopd_pos;
  assign w_sh_zero   = w_lopd_zero;
  assign w_in_ready  = w_out_room;

`else

  logic                 s1_valid_q, s1_valid_d;
  logic [SIZE_DATA-1:0] s1_mant_q,  s1_mant_d;
  logic [SIZE_EXP-1:0]  s1_exp_q,   s1_exp_d;
  logic [SIZE_POS-1:0]  s1_pos_q,   s1_pos_d;
  logic                 s1_zero_q,  s1_zero_d;
  logic                 w_s1_accept;

  // S1 frees up in the same cycle S2 takes its beat, so a full pipe still streams.
  assign w_in_ready  = !s1_valid_q || w_out_take;
  assign w_s1_accept = bus.i_valid && w_in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_pos_d   = s1_pos_q;
    s1_zero_d  = s1_zero_q;
    if (w_s1_accept) begin
      s1_valid_d = 1'b1;
      s1_mant_d  = bus.i_mant;
      s1_exp_d   = bus.i_exp;
      s1_pos_d   = w_lopd_pos;
      s1_zero_d  = w_lopd_zero;
    end else if (w_out_take) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_pos_q   <= '0;
      s1_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_pos_q   <= s1_pos_d;
      s1_zero_q  <= s1_zero_d;
    end
  end

  assign w_src_valid = s1_valid_q;
  assign w_sh_mant   = s1_mant_q;
  assign w_sh_exp    = s1_exp_q;
  assign w_sh_pos    = s1_pos_q;
  assign w_sh_zero   = s1_zero_q;

`endif

  // Exponent adjust and shift amount; compares run one bit wider than either operand.
  logic [CMP_W-1:0]     w_e_ext;
  logic [CMP_W-1:0]     w_p_ext;
  logic [CMP_W-1:0]     w_shift;
  logic [SIZE_EXP-1:0]  w_res_exp;
  logic                 w_res_zero;
  logic                 w_res_uf;
  logic [SIZE_DATA-1:0] w_res_mant;

  assign w_e_ext = CMP_W'(w_sh_exp);
  assign w_p_ext = CMP_W'(w_sh_pos);

  always_comb begin
    w_shift    = '0;
    w_res_exp  = '0;
    w_res_zero = 1'b0;
    w_res_uf   = 1'b0;
    if (w_sh_zero) begin
      w_res_zero = 1'b1;
    end else if (w_e_ext > w_p_ext) begin
      w_shift   = w_p_ext;
      w_res_exp = SIZE_EXP'(w_e_ext - w_p_ext);
    end else if (w_e_ext != '0) begin
      w_shift  = w_e_ext - CMP_W'(1);
      w_res_uf = 1'b1;
    end else begin
      w_res_uf = 1'b1;
    end
  end

  assign w_res_mant = w_sh_mant << w_shift;

  // Output register (S2)
  logic                 out_valid_d;
  logic [SIZE_DATA-1:0] out_mant_q, out_mant_d;
  logic [SIZE_EXP-1:0]  out_exp_q,  out_exp_d;
  logic                 out_zero_q, out_zero_d;
  logic                 out_uf_q,   out_uf_d;

  always_comb begin
    out_valid_d = w_out_room ? w_src_valid : out_valid_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_zero_d  = out_zero_q;
    out_uf_d    = out_uf_q;
    if (w_out_take) begin
      out_mant_d = w_res_mant;
      out_exp_d  = w_res_exp;
      out_zero_d = w_res_zero;
      out_uf_d   = w_res_uf;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uf_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_zero_q  <= out_zero_d;
      out_uf_q    <= out_uf_d;
    end
  end

  assign bus.o_ready     = w_in_ready;
  assign bus.o_valid     = out_valid_q;
  assign bus.o_mant      = out_mant_q;
  assign bus.o_exp       = out_exp_q;
  assign bus.o_zero_flag = out_zero_q;
  assign bus.o_underflow = out_uf_q;

endmodule
`default_nettype wire
